// File: rtl/bit_serializer.sv
// Purpose : parallel-to-serial stage; shifts DATA_W-bit words out one bit per bit_en strobe, MSB- or LSB-first, with frame markers.
// Latency : first bit of a word is presented the cycle after its s_valid/s_ready handshake; back-to-back words have no gap bit.
// Backpr. : s_ready is high only in IDLE or on the strobe of a word's last bit; clear and reset force it low. Nothing is buffered beyond shreg.
//
// Ports:
//   clk, rstn           clock (posedge) and asynchronous active-low reset
//   clear               synchronous abort: drop the word in flight, return to IDLE
//   bit_en              advance strobe: the presented bit is consumed when bit_en && ser_valid
//   s_data/s_valid/s_ready   parallel word input handshake
//   ser_bit/ser_valid   serial bit and its qualifier (busy mirrors ser_valid)
//   frame_start/frame_end    first/last bit of the current word
module bit_serializer #(
   parameter int DATA_W    = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clear,
   input  logic              bit_en,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              ser_bit,
   output logic              ser_valid,
   output logic              frame_start,
   output logic              frame_end,
   output logic              busy
);

   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nxt;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_nxt;

   logic last;
   logic adv;
   logic xfer;

   assign last = (cnt == LAST);
   assign adv  = (state == SHIFT) && bit_en;

   // rstn is part of the term so the block never advertises readiness while held in reset.
   assign s_ready = !clear && rstn && ((state == IDLE) || (adv && last));
   assign xfer    = s_valid && s_ready;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (xfer) state_nxt = SHIFT;
            // Last bit consumed with no follow-on word: drop back to IDLE.
            SHIFT:   if (adv && last && !xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Datapath next values: a handshake always reloads, even straight from the last bit.
   always_comb begin
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      if (clear) begin
         shreg_nxt = '0;
         cnt_nxt   = '0;
      end else if (xfer) begin
         shreg_nxt = s_data;
         cnt_nxt   = '0;
      end else if (adv) begin
         if (last) begin
            shreg_nxt = '0;
            cnt_nxt   = '0;
         end else begin
            shreg_nxt = MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};
            cnt_nxt   = cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shreg <= '0;
         cnt   <= '0;
      end else begin
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Output logic: driven only from registered state, so reset forces idle values immediately.
   always_comb begin
      ser_valid   = 1'b0;
      ser_bit     = IDLE_BIT;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      if (state == SHIFT) begin
         ser_valid   = 1'b1;
         ser_bit     = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];
         frame_start = (cnt == '0);
         frame_end   = last;
      end
   end

   assign busy = ser_valid;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn;

   // Main instance: DATA_W=8, MSB first
   logic       clear, bit_en, s_valid;
   logic [7:0] s_data;
   logic       s_ready, ser_bit, ser_valid, frame_start, frame_end, busy;

   // LSB-first instance
   logic       l_clear, l_bit_en, l_s_valid;
   logic [7:0] l_s_data;
   logic       l_s_ready, l_ser_bit, l_ser_valid, l_frame_start, l_frame_end, l_busy;

   // DATA_W=2 instance
   logic       w_clear, w_bit_en, w_s_valid;
   logic [1:0] w_s_data;
   logic       w_s_ready, w_ser_bit, w_ser_valid, w_frame_start, w_frame_end, w_busy;

   int tests_run    = 0;
   int tests_failed = 0;

   bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .clk(clk), .rstn(rstn), .clear(clear), .bit_en(bit_en),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .ser_bit(ser_bit), .ser_valid(ser_valid),
      .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
   );

   bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
      .clk(clk), .rstn(rstn), .clear(l_clear), .bit_en(l_bit_en),
      .s_data(l_s_data), .s_valid(l_s_valid), .s_ready(l_s_ready),
      .ser_bit(l_ser_bit), .ser_valid(l_ser_valid),
      .frame_start(l_frame_start), .frame_end(l_frame_end), .busy(l_busy)
   );

   bit_serializer #(.DATA_W(2), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_w2 (
      .clk(clk), .rstn(rstn), .clear(w_clear), .bit_en(w_bit_en),
      .s_data(w_s_data), .s_valid(w_s_valid), .s_ready(w_s_ready),
      .ser_bit(w_ser_bit), .ser_valid(w_ser_valid),
      .frame_start(w_frame_start), .frame_end(w_frame_end), .busy(w_busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // {ser_valid, ser_bit, frame_start, frame_end, busy}
   task automatic test_reset;
      rstn = 1'b0;
      clear = 1'b0; bit_en = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
      l_clear = 1'b0; l_bit_en = 1'b1; l_s_valid = 1'b0; l_s_data = 8'h00;
      w_clear = 1'b0; w_bit_en = 1'b1; w_s_valid = 1'b0; w_s_data = 2'b00;
      #3;
      tests_run++;
      if ({ser_valid, ser_bit, frame_start, frame_end, busy} !== 5'b00000) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %b expected 00000", {ser_valid, ser_bit, frame_start, frame_end, busy});
      end
      tests_run++;
      if (s_ready !== 1'b0) begin
         tests_failed++; $display("FAIL reset_s_ready: got %b expected 0", s_ready);
      end
      tick; tick;
      s_valid = 1'b0;
      rstn = 1'b1;
      #1;
      tests_run++;
      if ({s_ready, ser_valid} !== 2'b10) begin
         tests_failed++; $display("FAIL post_reset_idle: got %b expected 10", {s_ready, ser_valid});
      end
   endtask

   task automatic test_single_word;
      logic [7:0] w;
      logic [4:0] exp;
      w = 8'hA5;
      s_data = w; s_valid = 1'b1; bit_en = 1'b1;
      #1;
      tests_run++;
      if (s_ready !== 1'b1) begin
         tests_failed++; $display("FAIL single_hs_ready: got %b expected 1", s_ready);
      end
      tick;
      s_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp = {1'b1, w[7-i], (i == 0), (i == 7), 1'b1};
         tests_run++;
         if ({ser_valid, ser_bit, frame_start, frame_end, busy} !== exp) begin
            tests_failed++;
            $display("FAIL single_bit%0d: got %b expected %b", i, {ser_valid, ser_bit, frame_start, frame_end, busy}, exp);
         end
         tests_run++;
         if (s_ready !== (i == 7)) begin
            tests_failed++; $display("FAIL single_ready%0d: got %b expected %b", i, s_ready, (i == 7));
         end
         tick;
      end
      tests_run++;
      if ({ser_valid, ser_bit, frame_start, frame_end, busy} !== 5'b00000) begin
         tests_failed++;
         $display("FAIL single_idle_after: got %b expected 00000", {ser_valid, ser_bit, frame_start, frame_end, busy});
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] stream;
      logic [4:0]  exp;
      stream = 16'hA55A;
      s_data = 8'hA5; s_valid = 1'b1; bit_en = 1'b1;
      #1;
      tick;
      s_data = 8'h5A;
      for (int i = 0; i < 16; i++) begin
         if (i == 15) s_valid = 1'b0;
         #1;
         exp = {1'b1, stream[15-i], ((i % 8) == 0), ((i % 8) == 7), 1'b1};
         tests_run++;
         if ({ser_valid, ser_bit, frame_start, frame_end, busy} !== exp) begin
            tests_failed++;
            $display("FAIL b2b_bit%0d: got %b expected %b", i, {ser_valid, ser_bit, frame_start, frame_end, busy}, exp);
         end
         if (i < 15) begin
            tests_run++;
            if (s_ready !== (i == 7)) begin
               tests_failed++; $display("FAIL b2b_ready%0d: got %b expected %b", i, s_ready, (i == 7));
            end
         end
         tick;
      end
      tests_run++;
      if (ser_valid !== 1'b0) begin
         tests_failed++; $display("FAIL b2b_idle_after: got %b expected 0", ser_valid);
      end
   endtask

   task automatic test_bit_en_pulsed;
      logic [7:0] w;
      logic [3:0] exp;
      int b;
      w = 8'hC3;
      s_data = w; s_valid = 1'b1; bit_en = 1'b1;
      #1;
      tick;
      s_valid = 1'b0;
      for (int c = 0; c < 24; c++) begin
         bit_en = ((c % 3) == 2);
         #1;
         b = c / 3;
         exp = {1'b1, w[7-b], (b == 0), (b == 7)};
         tests_run++;
         if ({ser_valid, ser_bit, frame_start, frame_end} !== exp) begin
            tests_failed++;
            $display("FAIL strobe_cyc%0d: got %b expected %b", c, {ser_valid, ser_bit, frame_start, frame_end}, exp);
         end
         tests_run++;
         if (s_ready !== (c == 23)) begin
            tests_failed++; $display("FAIL strobe_ready%0d: got %b expected %b", c, s_ready, (c == 23));
         end
         tick;
      end
      bit_en = 1'b1;
      tests_run++;
      if (ser_valid !== 1'b0) begin
         tests_failed++; $display("FAIL strobe_idle_after: got %b expected 0", ser_valid);
      end
   endtask

   task automatic test_lsb_first;
      logic [7:0] w;
      logic [4:0] exp;
      w = 8'h01;
      l_s_data = w; l_s_valid = 1'b1; l_bit_en = 1'b1;
      #1;
      tests_run++;
      if (l_s_ready !== 1'b1) begin
         tests_failed++; $display("FAIL lsb_hs_ready: got %b expected 1", l_s_ready);
      end
      tick;
      l_s_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp = {1'b1, w[i], (i == 0), (i == 7), 1'b1};
         tests_run++;
         if ({l_ser_valid, l_ser_bit, l_frame_start, l_frame_end, l_busy} !== exp) begin
            tests_failed++;
            $display("FAIL lsb_bit%0d: got %b expected %b", i, {l_ser_valid, l_ser_bit, l_frame_start, l_frame_end, l_busy}, exp);
         end
         tick;
      end
      tests_run++;
      if ({l_ser_valid, l_ser_bit} !== 2'b00) begin
         tests_failed++; $display("FAIL lsb_idle_after: got %b expected 00", {l_ser_valid, l_ser_bit});
      end
   endtask

   task automatic test_clear;
      logic [7:0] w;
      logic [4:0] exp;
      clear = 1'b1; bit_en = 1'b1;
      #1;
      tests_run++;
      if (s_ready !== 1'b0) begin
         tests_failed++; $display("FAIL clear_idle_ready: got %b expected 0", s_ready);
      end
      clear = 1'b0;
      s_data = 8'hFF; s_valid = 1'b1;
      #1;
      tick;
      s_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if ({ser_valid, ser_bit} !== 2'b11) begin
            tests_failed++; $display("FAIL clear_pre_bit%0d: got %b expected 11", i, {ser_valid, ser_bit});
         end
         tick;
      end
      clear = 1'b1; s_valid = 1'b1; s_data = 8'h81;
      #1;
      tests_run++;
      if (s_ready !== 1'b0) begin
         tests_failed++; $display("FAIL clear_edge_ready: got %b expected 0", s_ready);
      end
      tick;
      clear = 1'b0;
      #1;
      tests_run++;
      if ({ser_valid, ser_bit, frame_start, frame_end, busy, s_ready} !== 6'b000001) begin
         tests_failed++;
         $display("FAIL clear_after: got %b expected 000001", {ser_valid, ser_bit, frame_start, frame_end, busy, s_ready});
      end
      tick;
      s_valid = 1'b0;
      w = 8'h81;
      for (int i = 0; i < 8; i++) begin
         exp = {1'b1, w[7-i], (i == 0), (i == 7), 1'b1};
         tests_run++;
         if ({ser_valid, ser_bit, frame_start, frame_end, busy} !== exp) begin
            tests_failed++;
            $display("FAIL clear_next_bit%0d: got %b expected %b", i, {ser_valid, ser_bit, frame_start, frame_end, busy}, exp);
         end
         tick;
      end
   endtask

   task automatic test_async_reset;
      logic [7:0] w;
      logic [4:0] exp;
      s_data = 8'hF0; s_valid = 1'b1; bit_en = 1'b1;
      #1;
      tick;
      s_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if ({ser_valid, ser_bit} !== 2'b11) begin
            tests_failed++; $display("FAIL arst_pre_bit%0d: got %b expected 11", i, {ser_valid, ser_bit});
         end
         tick;
      end
      tests_run++;
      if ({ser_valid, ser_bit} !== 2'b10) begin
         tests_failed++; $display("FAIL arst_bit4: got %b expected 10", {ser_valid, ser_bit});
      end
      #2;
      rstn = 1'b0; s_valid = 1'b1;
      #1;
      tests_run++;
      if ({ser_valid, ser_bit, frame_start, frame_end, busy, s_ready} !== 6'b000000) begin
         tests_failed++;
         $display("FAIL arst_immediate: got %b expected 000000", {ser_valid, ser_bit, frame_start, frame_end, busy, s_ready});
      end
      s_valid = 1'b0;
      tick;
      rstn = 1'b1;
      #1;
      tests_run++;
      if ({s_ready, ser_valid} !== 2'b10) begin
         tests_failed++; $display("FAIL arst_release: got %b expected 10", {s_ready, ser_valid});
      end
      tick;
      tests_run++;
      if ({ser_valid, ser_bit} !== 2'b00) begin
         tests_failed++; $display("FAIL arst_no_partial: got %b expected 00", {ser_valid, ser_bit});
      end
      w = 8'h3C;
      s_data = w; s_valid = 1'b1;
      #1;
      tick;
      s_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp = {1'b1, w[7-i], (i == 0), (i == 7), 1'b1};
         tests_run++;
         if ({ser_valid, ser_bit, frame_start, frame_end, busy} !== exp) begin
            tests_failed++;
            $display("FAIL arst_new_bit%0d: got %b expected %b", i, {ser_valid, ser_bit, frame_start, frame_end, busy}, exp);
         end
         tick;
      end
   endtask

   task automatic test_width2;
      logic [3:0] stream;
      logic [3:0] exp;
      stream = 4'b0110;
      w_s_data = 2'b01; w_s_valid = 1'b1; w_bit_en = 1'b1;
      #1;
      tick;
      w_s_data = 2'b10;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) w_s_valid = 1'b0;
         #1;
         exp = {1'b1, stream[3-i], ((i % 2) == 0), ((i % 2) == 1)};
         tests_run++;
         if ({w_ser_valid, w_ser_bit, w_frame_start, w_frame_end} !== exp) begin
            tests_failed++;
            $display("FAIL w2_bit%0d: got %b expected %b", i, {w_ser_valid, w_ser_bit, w_frame_start, w_frame_end}, exp);
         end
         tick;
      end
      tests_run++;
      if (w_ser_valid !== 1'b0) begin
         tests_failed++; $display("FAIL w2_idle_after: got %b expected 0", w_ser_valid);
      end
   endtask

   initial begin
      test_reset;
      test_single_word;
      test_back_to_back;
      test_bit_en_pulsed;
      test_lsb_first;
      test_clear;
      test_async_reset;
      test_width2;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
